// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the 5-stage RISC-V core: ALU control codes used by
//   the EX stage and the state encoding of the multiply sequencer.
//   No ports (package).
// ---------------------------------------------------------------------------
package cpu_pkg;

   // ALU control codes driven by the decoder into EX
   localparam logic [3:0] AND_OP = 4'd0;
   localparam logic [3:0] OR_OP  = 4'd1;
   localparam logic [3:0] ADD_OP = 4'd2;
   localparam logic [3:0] XOR_OP = 4'd3;
   localparam logic [3:0] SLL_OP = 4'd4;
   localparam logic [3:0] SRL_OP = 4'd5;
   localparam logic [3:0] SUB_OP = 4'd6;
   localparam logic [3:0] SLT_OP = 4'd7;
   localparam logic [3:0] MUL_OP = 4'd8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } mul_seq_state_t;

   // A multiply request is a real EX instruction carrying the MUL code that
   // is not being flushed this cycle.
   function automatic logic is_mul_req(input logic valid, input logic [3:0] ctrl,
                                       input logic kill);
      return valid & (ctrl == MUL_OP) & ~kill;
   endfunction

endpackage

// File: rtl/mul_result_cache.sv
// ---------------------------------------------------------------------------
// mul_result_cache
//   Single-entry last-operand tag for the multiply sequencer. Remembers the
//   operands and low-half product of the most recently completed MUL so an
//   identical MUL can skip the multiplier. The entry is invalid only after
//   reset; once written it stays valid and is overwritten on every write.
// Ports
//   clk, rst_n            clock / synchronous active-low reset
//   wr_en                 write the entry (one pulse per completed MUL)
//   wr_a, wr_b, wr_result operands and result to store
//   lookup_a, lookup_b    operands currently in EX
//   hit                   entry valid and both operands match
//   hit_result            stored result
// ---------------------------------------------------------------------------
module mul_result_cache #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_a,
   input  logic [DATA_W-1:0] wr_b,
   input  logic [DATA_W-1:0] wr_result,
   input  logic [DATA_W-1:0] lookup_a,
   input  logic [DATA_W-1:0] lookup_b,
   output logic              hit,
   output logic [DATA_W-1:0] hit_result
);

   logic [DATA_W-1:0] tag_a_q, tag_a_d;
   logic [DATA_W-1:0] tag_b_q, tag_b_d;
   logic [DATA_W-1:0] tag_r_q, tag_r_d;
   logic              tag_v_q, tag_v_d;

   always_comb begin
      tag_a_d = tag_a_q;
      tag_b_d = tag_b_q;
      tag_r_d = tag_r_q;
      tag_v_d = tag_v_q;
      if (wr_en) begin
         tag_a_d = wr_a;
         tag_b_d = wr_b;
         tag_r_d = wr_result;
         tag_v_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tag_a_q <= '0;
         tag_b_q <= '0;
         tag_r_q <= '0;
         tag_v_q <= 1'b0;
      end else begin
         tag_a_q <= tag_a_d;
         tag_b_q <= tag_b_d;
         tag_r_q <= tag_r_d;
         tag_v_q <= tag_v_d;
      end
   end

   assign hit        = tag_v_q && (lookup_a == tag_a_q) && (lookup_b == tag_b_q);
   assign hit_result = tag_r_q;

endmodule

// File: rtl/mul_sequencer.sv
// ---------------------------------------------------------------------------
// mul_sequencer
//   Drives the fixed-latency multiplier for the EX stage. A MUL seen in EX
//   (IDLE) stalls the front of the pipe, launches the multiplier with
//   registered operands, waits MUL_LATENCY cycles, captures the low half of
//   the product and presents it for exactly one cycle (DONE) while the
//   pipeline advances. A flush while waiting abandons the operation.
//
//   Optional feature macro: MUL_RESULT_CACHE_EN
//     When defined, a repeat of the last completed MUL (same operands) is
//     answered from a one-entry tag with a single stall cycle and no launch.
//
// Ports
//   clk, rst_n        clock / synchronous active-low reset
//   ex_valid          EX holds a real instruction
//   ex_alu_ctrl       ALU control code of the EX instruction
//   ex_op_a, ex_op_b  forwarded operands
//   flush             branch/jump flush of EX
//   mul_start         one-cycle launch pulse to the multiplier
//   mul_a, mul_b      registered multiplier operands
//   mul_p             multiplier product (low DATA_W bits used)
//   stall             freeze IF/ID/EX, bubble into MEM
//   mul_result        captured product, stable while mul_valid
//   mul_valid         EX selects mul_result this cycle
// ---------------------------------------------------------------------------
module mul_sequencer
   import cpu_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int MUL_LATENCY = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ex_valid,
   input  logic [3:0]          ex_alu_ctrl,
   input  logic [DATA_W-1:0]   ex_op_a,
   input  logic [DATA_W-1:0]   ex_op_b,
   input  logic                flush,
   output logic                mul_start,
   output logic [DATA_W-1:0]   mul_a,
   output logic [DATA_W-1:0]   mul_b,
   input  logic [2*DATA_W-1:0] mul_p,
   output logic                stall,
   output logic [DATA_W-1:0]   mul_result,
   output logic                mul_valid
);

   localparam int CNT_W = $clog2(MUL_LATENCY + 1);

   mul_seq_state_t    state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              mul_start_q, mul_start_d;
   logic [DATA_W-1:0] mul_a_q, mul_a_d;
   logic [DATA_W-1:0] mul_b_q, mul_b_d;
   logic [DATA_W-1:0] mul_result_q, mul_result_d;
   logic              mul_valid_q, mul_valid_d;

   logic              req;
   logic              stall_raw;
   logic              cache_hit;
   logic              cache_wr;
   logic [DATA_W-1:0] cache_result;

   // Only the low half of the product is architecturally visible.
   logic unused_p_hi;
   assign unused_p_hi = ^mul_p[2*DATA_W-1:DATA_W];

   assign req = is_mul_req(ex_valid, ex_alu_ctrl, flush);

`ifdef MUL_RESULT_CACHE_EN
   mul_result_cache #(
      .DATA_W(DATA_W)
   ) u_cache (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (cache_wr),
      .wr_a      (mul_a_q),
      .wr_b      (mul_b_q),
      .wr_result (mul_result_q),
      .lookup_a  (ex_op_a),
      .lookup_b  (ex_op_b),
      .hit       (cache_hit),
      .hit_result(cache_result)
   );
`else
   logic unused_cache_wr;
   assign unused_cache_wr = cache_wr;
   assign cache_hit       = 1'b0;
   assign cache_result    = '0;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      mul_start_d  = 1'b0;
      mul_a_d      = mul_a_q;
      mul_b_d      = mul_b_q;
      mul_result_d = mul_result_q;
      mul_valid_d  = 1'b0;
      stall_raw    = 1'b0;
      cache_wr     = 1'b0;

      case (state_q)
         IDLE: begin
            stall_raw = req;
            if (req) begin
               // Operands are latched on hits too, so the tag written in
               // DONE always pairs the right operands with the result.
               mul_a_d = ex_op_a;
               mul_b_d = ex_op_b;
               if (cache_hit) begin
                  mul_result_d = cache_result;
                  mul_valid_d  = 1'b1;
                  state_d      = DONE;
               end else begin
                  mul_start_d = 1'b1;
                  cnt_d       = CNT_W'(MUL_LATENCY);
                  state_d     = WAIT;
               end
            end
         end

         WAIT: begin
            if (flush) begin
               // Abandon: the in-flight product is simply never captured.
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               stall_raw = 1'b1;
               cnt_d     = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  mul_result_d = mul_p[DATA_W-1:0];
                  mul_valid_d  = 1'b1;
                  state_d      = DONE;
               end
            end
         end

         DONE: begin
            // EX still holds the finished MUL this cycle, so req is ignored
            // here; flush is ignored as well and the result is presented.
            cache_wr = 1'b1;
            state_d  = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         mul_start_q  <= 1'b0;
         mul_a_q      <= '0;
         mul_b_q      <= '0;
         mul_result_q <= '0;
         mul_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mul_start_q  <= mul_start_d;
         mul_a_q      <= mul_a_d;
         mul_b_q      <= mul_b_d;
         mul_result_q <= mul_result_d;
         mul_valid_q  <= mul_valid_d;
      end
   end

   // Stall is combinational from the request; held low while in reset.
   assign stall      = stall_raw & rst_n;
   assign mul_start  = mul_start_q;
   assign mul_a      = mul_a_q;
   assign mul_b      = mul_b_q;
   assign mul_result = mul_result_q;
   assign mul_valid  = mul_valid_q;

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;
   import cpu_pkg::*;

   localparam int DW  = 32;
   localparam int LAT = 4;
`ifdef MUL_RESULT_CACHE_EN
   localparam bit CACHE_EN = 1'b1;
`else
   localparam bit CACHE_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ex_valid;
   logic [3:0]    ex_alu_ctrl;
   logic [DW-1:0] ex_op_a, ex_op_b;
   logic          flush;
   logic          mul_start;
   logic [DW-1:0] mul_a, mul_b;
   logic [2*DW-1:0] mul_p;
   logic          stall;
   logic [DW-1:0] mul_result;
   logic          mul_valid;

   always #5 clk = ~clk;

   mul_sequencer #(.DATA_W(DW), .MUL_LATENCY(LAT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ex_valid   (ex_valid),
      .ex_alu_ctrl(ex_alu_ctrl),
      .ex_op_a    (ex_op_a),
      .ex_op_b    (ex_op_b),
      .flush      (flush),
      .mul_start  (mul_start),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_p      (mul_p),
      .stall      (stall),
      .mul_result (mul_result),
      .mul_valid  (mul_valid)
   );

   // Multiplier model: product of the registered operands, valid LAT-1
   // cycles after the mul_start cycle (i.e. on the last stall cycle);
   // garbage otherwise so an early/late capture is visible.
   logic [2*DW-1:0] p1, p2, p3;
   logic            v1, v2, v3;
   always_ff @(posedge clk) begin
      v1 <= mul_start;
      p1 <= {{DW{1'b0}}, mul_a} * {{DW{1'b0}}, mul_b};
      v2 <= v1;
      p2 <= p1;
      v3 <= v2;
      p3 <= p2;
   end
   assign mul_p = v3 ? p3 : 64'hDEAD_BEEF_0BAD_F00D;

   int passed = 0;
   int total  = 0;
   logic [DW-1:0] sb_q[$];

   // Bench-side model of the result tag (only used with the cache enabled)
   logic          tag_v = 1'b0;
   logic [DW-1:0] tag_a, tag_b;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   typedef struct {
      logic          vld;
      logic [3:0]    ctrl;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      int            flush_at;  // cycle index of flush within the op, -1 none
      bit            chg;       // scramble operands/ctrl after detection
      logic [DW-1:0] exp;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs[NV];

   // Apply one EX instruction, holding it while stalled, and check counts.
   task automatic run_op(input int idx, input vec_t v);
      bit   is_mul, hit, done;
      int   e_stall, e_start, e_valid;
      int   n_stall, n_start, n_valid;
      logic [DW-1:0] got;
      is_mul = v.vld && (v.ctrl == MUL_OP);
      hit    = CACHE_EN && tag_v && (v.a == tag_a) && (v.b == tag_b);
      if (!is_mul || v.flush_at == 0) begin
         e_stall = 0; e_start = 0; e_valid = 0;
      end else if (hit) begin
         e_stall = 1; e_start = 0; e_valid = 1;
      end else if (v.flush_at > 0 && v.flush_at <= LAT) begin
         e_stall = v.flush_at; e_start = 1; e_valid = 0;
      end else begin
         e_stall = LAT + 1; e_start = 1; e_valid = 1;
      end
      if (e_valid == 1) begin
         sb_q.push_back(v.exp);
         tag_v = 1'b1; tag_a = v.a; tag_b = v.b;
      end
      n_stall = 0; n_start = 0; n_valid = 0; done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         ex_valid    = v.vld;
         ex_alu_ctrl = (v.chg && i >= 1) ? ADD_OP : v.ctrl;
         ex_op_a     = (v.chg && i >= 1) ? ~v.a : v.a;
         ex_op_b     = (v.chg && i >= 1) ? v.b + 32'd1 : v.b;
         flush       = (i == v.flush_at);
         #1;
         if (stall) n_stall++;
         if (mul_start) n_start++;
         if (mul_valid) begin
            n_valid++;
            if (sb_q.size() == 0) chk($sformatf("v%0d unexpected mul_valid", idx), 32'd1, 32'd0);
            else begin
               got = sb_q.pop_front();
               chk($sformatf("v%0d mul_result", idx), mul_result, got);
            end
         end
         if (!stall) done = 1;
      end
      if (!done) chk($sformatf("v%0d stall timeout", idx), 32'd1, 32'd0);
      chk($sformatf("v%0d stall cycles", idx), n_stall, e_stall);
      chk($sformatf("v%0d mul_start pulses", idx), n_start, e_start);
      chk($sformatf("v%0d mul_valid cycles", idx), n_valid, e_valid);
      $display("op %0d: vld=%0b ctrl=%0d a=0x%08h b=0x%08h flush_at=%0d stall=%0d start=%0d valid=%0d",
               idx, v.vld, v.ctrl, v.a, v.b, v.flush_at, n_stall, n_start, n_valid);
   endtask

   initial begin
      int n_v;
      vecs[0]  = '{1'b1, ADD_OP, 32'd5,          32'd9,          -1, 1'b0, 32'd0};
      vecs[1]  = '{1'b1, MUL_OP, 32'd7,          32'd6,          -1, 1'b0, 32'd42};
      vecs[2]  = '{1'b1, MUL_OP, 32'd3,          32'd5,           2, 1'b0, 32'd0};
      vecs[3]  = '{1'b1, SUB_OP, 32'd8,          32'd1,          -1, 1'b0, 32'd0};
      vecs[4]  = '{1'b1, MUL_OP, 32'hFFFF_FFFE,  32'd3,          -1, 1'b0, 32'hFFFF_FFFA};
      vecs[5]  = '{1'b1, MUL_OP, 32'h0000_FFFF,  32'h0001_0001,  -1, 1'b0, 32'hFFFF_FFFF};
      vecs[6]  = '{1'b1, MUL_OP, 32'd9,          32'd9,          -1, 1'b0, 32'd81};
      vecs[7]  = '{1'b1, MUL_OP, 32'd9,          32'd9,          -1, 1'b0, 32'd81};
      vecs[8]  = '{1'b1, MUL_OP, 32'd1234,       32'd5678,       -1, 1'b1, 32'd7006652};
      vecs[9]  = '{1'b1, MUL_OP, 32'h8000_0000,  32'd2,          -1, 1'b0, 32'd0};
      vecs[10] = '{1'b0, MUL_OP, 32'd4,          32'd4,          -1, 1'b0, 32'd0};
      vecs[11] = '{1'b1, 4'd9,   32'd4,          32'd4,          -1, 1'b0, 32'd0};
      vecs[12] = '{1'b1, MUL_OP, 32'd3,          32'd5,           1, 1'b0, 32'd0};
      vecs[13] = '{1'b1, MUL_OP, 32'd3,          32'd5,           0, 1'b0, 32'd0};
      vecs[14] = '{1'b1, MUL_OP, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  -1, 1'b0, 32'd1};

      // Reset held with a MUL sitting in EX
      rst_n = 1'b0; ex_valid = 1'b1; ex_alu_ctrl = MUL_OP;
      ex_op_a = 32'd1; ex_op_b = 32'd1; flush = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset stall", stall, 1'b0);
      chk("reset mul_start", mul_start, 1'b0);
      chk("reset mul_valid", mul_valid, 1'b0);
      chk("reset mul_result", mul_result, 32'd0);
      @(negedge clk);
      ex_valid = 1'b0;
      rst_n    = 1'b1;

      for (int k = 0; k < NV; k++) run_op(k, vecs[k]);

      // Reset in the middle of a MUL
      @(negedge clk);
      ex_valid = 1'b1; ex_alu_ctrl = MUL_OP; ex_op_a = 32'd11; ex_op_b = 32'd13; flush = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("mid-op stall before reset", stall, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      chk("mid-op reset stall", stall, 1'b0);
      chk("mid-op reset mul_start", mul_start, 1'b0);
      chk("mid-op reset mul_valid", mul_valid, 1'b0);
      chk("mid-op reset mul_result", mul_result, 32'd0);
      chk("mid-op reset mul_a", mul_a, 32'd0);
      ex_valid = 1'b0;
      rst_n    = 1'b1;
      n_v = 0;
      repeat (8) begin
         @(negedge clk);
         #1;
         if (mul_valid || stall) n_v++;
      end
      chk("after reset quiet cycles", n_v, 0);
      chk("scoreboard drained", sb_q.size(), 0);
      $display("mid-op reset sequence done");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
